axis_load_sweep_ctrl: RTL
=========================

// Module: axis_load_sweep_ctrl
// PURPOSE
// Synthesizable sequencer for a mesh-NoC traffic harness of NUM_TG traffic generators plus checkers.
// It steps through a table of injection loads. For each point it resets the harness, drives the load, starts all
// generators and waits for every generator done with sum_sent==sum_recv, or for a timeout. It then emits one result record.
// Sits between a host/CSR block and the tg/checker array; replaces the procedural sweep used in simulation.
// PARAMETERS
// NUM_TG        16  number of traffic generators / checkers
// NUM_LOADS     12  entries in load_table
// LOAD_WIDTH    16  load fraction, full scale = 2**LOAD_WIDTH-1
// COUNT_WIDTH   32  width of packet sums and cycle counter
// RESET_CYCLES  6   cycles tg_rst_n held low per point (>=1)
// START_DELAY   5   cycles between tg_rst_n release and start assertion (>=1)
// DRAIN_CYCLES  3   cycles after the result record before the next point (>=1)
// TIMEOUT       2**31  RUN-state cycle limit, COUNT_WIDTH-bit compare
// PORTS
// clk            in   1                      single clock
// rst_n          in   1                      async active-low reset
// go             in   1                      rising edge in IDLE launches a sweep
// abort          in   1                      sync abort; any state -> IDLE
// load_table     in   NUM_LOADS*LOAD_WIDTH   entry k at [k*LOAD_WIDTH +: LOAD_WIDTH]
// tg_rst_n       out  1                      harness reset, active low
// load           out  LOAD_WIDTH             current load, held stable for the whole point
// start          out  NUM_TG                 per-generator start
// done           in   NUM_TG                 per-generator done
// error          in   NUM_TG                 per-checker error, sticky in checker
// sum_sent       in   COUNT_WIDTH            total packets sent by all generators
// sum_recv       in   COUNT_WIDTH            total packets received by all checkers
// busy           out  1                      high in every state except IDLE
// result_valid   out  1                      1-cycle pulse per completed point
// result_idx     out  $clog2(NUM_LOADS)      index of the reported point
// result_error   out  NUM_TG                 error[] sampled at REPORT
// result_timeout out  1                      point ended by timeout
// result_cycles  out  COUNT_WIDTH            RUN duration, only with macro
// sweep_done     out  1                      1-cycle pulse after the last point
// BEHAVIOUR
// - Reset values: tg_rst_n=0, start=0, load=0, busy=0; all result_* = 0; sweep_done=0; state IDLE, idx=0.
// - All outputs are registered. A single down-counter serves every timed state.
// - IDLE: tg_rst_n=0. On a rising edge of go (go registered, not level): idx=0, load=table[0], -> RESET.
// - RESET: tg_rst_n=0 for exactly RESET_CYCLES cycles -> SETTLE.
// - SETTLE: tg_rst_n=1, start=0 for START_DELAY cycles -> RUN. On entry to RUN, start is all ones and the timer clears.
// - RUN: when done[i]=1, start[i] drops to 0 the next cycle and stays 0 until the next point, even if done[i] deasserts.
//   Exit condition A: all start bits already dropped, done all ones, and sum_sent==sum_recv, all in the same cycle.
//   Condition A -> REPORT with timeout=0.
//   Exit condition B: timer >= TIMEOUT -> REPORT with timeout=1. If A and B hold in the same cycle, A wins.
//   If all are done but the counts differ, keep waiting; only the timeout ends the point.
// - REPORT: a single cycle. Drives result_valid=1 with idx, error[] and timeout. start is all zero.
//   result_* hold their value until the next REPORT. -> DRAIN.
// - DRAIN: DRAIN_CYCLES cycles with tg_rst_n=1.
//   Then, if idx==NUM_LOADS-1: pulse sweep_done, -> IDLE with tg_rst_n=0.
//   Otherwise idx+=1, load=table[idx], -> RESET.
// - load updates only on the transition into RESET.
// - abort: the next cycle gives tg_rst_n=0, start=0 and state IDLE. No result_valid and no sweep_done are produced.
// - go while busy is ignored. An async reset mid-sweep returns everything to reset values.
// - Timer saturates at all ones and never wraps.
// - The sums are compared as unsigned COUNT_WIDTH values; wrap of the counters is the harness's concern.
// CONFIGURATION
// - LOAD_SWEEP_CYCLES_EN defined: the RUN timer value is latched into result_cycles at REPORT.
//   The value counts cycles from RUN entry to the exit cycle, inclusive.
// - LOAD_SWEEP_CYCLES_EN undefined: result_cycles is tied to 0. The timer is still present for the timeout.
// TESTING
// 1 Reset: rst_n=0 mid-RUN -> tg_rst_n=0, start=0, busy=0 in the same cycle (async). No result_valid after release.
// 2 Nominal, NUM_LOADS=2, table {655,6553}, all done 20 cycles into RUN, sums 100/100:
//   tg_rst_n low for 6 cycles, start 5 cycles after release, two result_valid (idx 0,1, timeout=0), one sweep_done.
// 3 Staggered done (done[3] 10 cycles after the others, and it deasserts 1 cycle later):
//   start[3] stays 0 once dropped; REPORT comes 1 cycle after the last done.
// 4 Count mismatch, TIMEOUT=50: all done, sent=100, recv=99 held -> REPORT exactly at timer 50 with result_timeout=1.
//   Same cycle recv=100 and timer=50 -> timeout=0.
// 5 abort asserted during DRAIN of point 0 -> IDLE next cycle, no further result_valid, sweep_done stays 0.
//   go while busy has no effect.
// 6 With LOAD_SWEEP_CYCLES_EN, exit 20 cycles into RUN -> result_cycles=20. Without the macro -> result_cycles=0.

Source files
------------

// File: rtl/axis_load_sweep_ctrl.sv
// axis_load_sweep_ctrl: steps a NoC traffic harness through a load table, one result record per point; LOAD_SWEEP_CYCLES_EN reports RUN duration in result_cycles
module axis_load_sweep_ctrl #(
  parameter int NUM_TG = 16,
  parameter int NUM_LOADS = 12,
  parameter int LOAD_WIDTH = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int RESET_CYCLES = 6,
  parameter int START_DELAY = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter longint unsigned TIMEOUT = 64'h8000_0000,
  localparam int IW = NUM_LOADS > 1 ? $clog2(NUM_LOADS) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic abort,
  input  logic [NUM_LOADS*LOAD_WIDTH-1:0] load_table,
  output logic tg_rst_n,
  output logic [LOAD_WIDTH-1:0] load,
  output logic [NUM_TG-1:0] start,
  input  logic [NUM_TG-1:0] done,
  input  logic [NUM_TG-1:0] error,
  input  logic [COUNT_WIDTH-1:0] sum_sent,
  input  logic [COUNT_WIDTH-1:0] sum_recv,
  output logic busy,
  output logic result_valid,
  output logic [IW-1:0] result_idx,
  output logic [NUM_TG-1:0] result_error,
  output logic result_timeout,
  output logic [COUNT_WIDTH-1:0] result_cycles,
  output logic sweep_done
);
  localparam int DMAX = RESET_CYCLES > START_DELAY ?
    (RESET_CYCLES > DRAIN_CYCLES ? RESET_CYCLES : DRAIN_CYCLES) :
    (START_DELAY > DRAIN_CYCLES ? START_DELAY : DRAIN_CYCLES);
  localparam int CW = $clog2(DMAX + 1);
  localparam logic [COUNT_WIDTH-1:0] TMO = COUNT_WIDTH'(TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(NUM_LOADS - 1);
  typedef enum logic [2:0] {IDLE, RESET, SETTLE, RUN, REPORT, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [COUNT_WIDTH-1:0] timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic [LOAD_WIDTH-1:0] tbl [NUM_LOADS];
  logic [LOAD_WIDTH-1:0] load_n;
  logic [NUM_TG-1:0] start_n;
  logic go_q, sd_n, cond_a, cond_b, fin;
  for (genvar k = 0; k < NUM_LOADS; k++) begin : g_tbl
    assign tbl[k] = load_table[k*LOAD_WIDTH +: LOAD_WIDTH];
  end
  assign cond_a = start == '0 && &done && sum_sent == sum_recv;
  assign cond_b = timer >= TMO;
  assign fin = state == RUN && (cond_a || cond_b) && !abort;
  always_comb begin
    state_n = state;
    cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
    idx_n = idx;
    load_n = load;
    timer_n = '0;
    start_n = '0;
    sd_n = 1'b0;
    if (abort)
      state_n = IDLE;
    else
      case (state)
        IDLE: if (go & ~go_q) begin
          state_n = RESET;
          idx_n = '0;
          load_n = tbl[0];
          cnt_n = CW'(RESET_CYCLES - 1);
        end
        RESET: if (cnt == '0) begin
          state_n = SETTLE;
          cnt_n = CW'(START_DELAY - 1);
        end
        SETTLE: if (cnt == '0) begin
          state_n = RUN;
          start_n = '1;
        end
        RUN: begin
          timer_n = &timer ? timer : timer + COUNT_WIDTH'(1);
          start_n = fin ? '0 : start & ~done;
          state_n = fin ? REPORT : RUN;
        end
        REPORT: begin
          state_n = DRAIN;
          cnt_n = CW'(DRAIN_CYCLES - 1);
        end
        DRAIN: if (cnt == '0) begin
          state_n = idx == LAST ? IDLE : RESET;
          sd_n = idx == LAST;
          idx_n = idx == LAST ? idx : idx + IW'(1);
          load_n = idx == LAST ? load : tbl[idx + IW'(1)];
          cnt_n = idx == LAST ? cnt : CW'(RESET_CYCLES - 1);
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      idx <= '0;
      go_q <= 1'b0;
      tg_rst_n <= 1'b0;
      load <= '0;
      start <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result_idx <= '0;
      result_error <= '0;
      result_timeout <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      timer <= timer_n;
      idx <= idx_n;
      go_q <= go;
      load <= load_n;
      start <= start_n;
      tg_rst_n <= state_n inside {SETTLE, RUN, REPORT, DRAIN};
      busy <= state_n != IDLE;
      result_valid <= fin;
      sweep_done <= sd_n;
      if (fin) begin
        result_idx <= idx;
        result_error <= error;
        result_timeout <= !cond_a;
      end
    end
`ifdef LOAD_SWEEP_CYCLES_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      result_cycles <= '0;
    else if (fin)
      result_cycles <= timer_n;
`else
  assign result_cycles = '0;
`endif
endmodule
